cpu_divider_n: RTL and testbench
================================

# cpu_divider_n

Parametrised iterative integer divider: the successor to the fixed 32-bit, one-bit-per-cycle divider that feeds the completion stage of the CPU pipeline. Operand width and bits retired per cycle are configurable. The block adds single-cycle fast paths for divide-by-zero and signed overflow, a synchronous abort driven by the pipeline flush, and a level-held done/result pair that survives pipeline stalls. It sits beside the execute stage: it is started from p3 operands and consumed in p4.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1, quotient bits retired per iteration cycle; legal values 1, 2, 4.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a division; accepted only when busy=0.
- abort  in  1  pipeline flush; cancels any division in progress.
- signed_div  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- data_a  in  WIDTH  dividend; sampled with start.
- data_b  in  WIDTH  divisor; sampled with start.
- busy  out  1  division in progress.
- done  out  1  result valid; held high until the next accepted start, abort or reset.
- quotient  out  WIDTH  quotient; held stable while done=1.
- remainder  out  WIDTH  remainder; held stable while done=1.
- div_by_zero  out  1  qualifies done: the divisor was zero.

## Operation
- ITER = WIDTH/BITS_PER_CYCLE. Iteration counter width is $clog2(ITER+1).
- FSM states: DIV_IDLE, DIV_RUN, DIV_FIX.
  - DIV_IDLE: on start with abort=0, capture operands and clear done.
  - From DIV_IDLE, a normal case moves to DIV_RUN with counter=ITER.
  - From DIV_IDLE, a fast-path case writes the result directly, sets done=1 and stays in DIV_IDLE.
  - DIV_RUN: each cycle performs BITS_PER_CYCLE chained restoring steps on magnitudes and decrements the counter. When the counter reaches 1, move to DIV_FIX.
  - DIV_FIX: apply signs, register quotient, remainder and done=1, then move to DIV_IDLE.
- Signed operands are converted to WIDTH-bit unsigned magnitudes; |MIN| fits unsigned.
- Quotient is negated when sign_a XOR sign_b. Remainder takes the sign of the dividend, so quotient truncates toward zero.
- Unsigned mode: no sign handling.
- Fast paths, detected combinationally at start:
  - data_b=0: quotient = all ones, remainder = data_a, div_by_zero=1. Applies in both modes.
  - signed_div=1, data_a=MIN, data_b=all ones: quotient = MIN, remainder = 0, div_by_zero=0.
- start while busy=1 is ignored; the in-flight operation is unaffected.
- abort in any state: next state DIV_IDLE, busy=0, done=0. quotient and remainder hold their previous values (don't-care).
- abort and start in the same cycle: abort wins and start is dropped.
- start in a cycle with done=1 is legal (back-to-back operation). done falls on the following edge.
- reset overrides everything, including mid-operation.

## Timing
- Reset values: state DIV_IDLE, busy 0, done 0, quotient 0, remainder 0, div_by_zero 0.
- Normal path, start sampled at the edge ending cycle T:
  - busy=1 in cycles T+1..T+ITER+1.
  - done=1 from cycle T+ITER+2 onward.
  - Latency is therefore ITER+2: 34 cycles for 32/1, 18 for 32/2, 10 for 32/4.
- Fast path: done=1 and results valid in cycle T+1; busy is never asserted.
- div_by_zero is updated on the same edge as done and cleared on start, abort or reset.
- No combinational path from any input to any output.

## Structure
- Package cpu_div_pkg holds:
  - typedef enum div_state_t {DIV_IDLE, DIV_RUN, DIV_FIX};
  - a localparam function computing ITER and the counter width.
- Sub-module cpu_div_step: one combinational restoring step (shift-in bit, trial subtract, select). It is instantiated BITS_PER_CYCLE times in a generate chain.
- Top module holds the FSM, counter, operand and sign registers, fast-path detect and sign fix-up.

## Test plan
- 32/1 unsigned, 100/7, start at T → busy over T+1..T+33; done at T+34 with quotient 14, remainder 2, div_by_zero 0.
- Signed cases:
  - −7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - 7/−2 → quotient 0xFFFFFFFD, remainder 1.
  - −8/−3 → quotient 2, remainder 0xFFFFFFFE.
- Fast paths:
  - 5/0 unsigned → done at T+1, quotient 0xFFFFFFFF, remainder 5, div_by_zero 1.
  - Signed 0x80000000/0xFFFFFFFF → done at T+1, quotient 0x80000000, remainder 0.
- Abort:
  - Start 1000/3, abort at T+10 → busy=0 and done=0 at T+11; quotient/remainder not checked.
  - Abort together with start → start dropped.
  - Fresh start 9/3 → quotient 3, remainder 0 at full latency.
- 32/2: 0xFFFFFFFF/3 unsigned → done at T+18, quotient 0x55555555, remainder 0. A start pulse at T+5 with other operands is ignored and the result is unchanged.
- Back-to-back and stall:
  - Second start issued in the first done cycle → done drops next cycle and the second result appears ITER+2 cycles later.
  - With no new start, done and results hold for 50 idle cycles.
  - reset mid-DIV_RUN → all outputs return to their reset values.

Source files
------------

// File: rtl/cpu_div_pkg.sv
// Shared types and sizing helpers for the iterative divider.
package cpu_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_FIX
    } div_state_t;

    function automatic int unsigned div_iter(input int unsigned width,
                                             input int unsigned bits_per_cycle);
        return width / bits_per_cycle;
    endfunction

    function automatic int unsigned div_cnt_w(input int unsigned iter);
        return int'($clog2(iter + 1));
    endfunction

endpackage

// File: rtl/cpu_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module cpu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;

    // The partial remainder is always below the divisor, so WIDTH+1 bits suffice.
    assign w_trial = {rem_in, quo_in[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, divisor};

    always_comb begin
        rem_out = w_trial[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], 1'b0};
        if (!w_diff[WIDTH]) begin
            rem_out = w_diff[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/cpu_divider_n.sv
// Iterative signed/unsigned divider retiring BITS_PER_CYCLE quotient bits per
// cycle, with single-cycle divide-by-zero and overflow fast paths.
module cpu_divider_n
    import cpu_div_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned ITER  = div_iter(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned CNT_W = div_cnt_w(ITER);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_done;
    logic             r_dbz;

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;
    logic             w_ovf;
    logic             w_fast;

    logic [WIDTH-1:0] w_rem_c [0:BITS_PER_CYCLE];
    logic [WIDTH-1:0] w_quo_c [0:BITS_PER_CYCLE];

    assign w_accept = start && !abort && (r_state == DIV_IDLE);
    assign w_a_neg  = signed_div && data_a[WIDTH-1];
    assign w_b_neg  = signed_div && data_b[WIDTH-1];
    // Negating MIN yields MIN, which is exactly |MIN| read as unsigned.
    assign w_a_mag  = w_a_neg ? -data_a : data_a;
    assign w_b_mag  = w_b_neg ? -data_b : data_b;
    assign w_b_zero = (data_b == '0);
    assign w_ovf    = signed_div && (data_a == MIN_VAL) && (data_b == '1);
    assign w_fast   = w_b_zero || w_ovf;

    assign w_rem_c[0] = r_rem;
    assign w_quo_c[0] = r_quo;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        cpu_div_step #(
            .WIDTH(WIDTH)
        ) u_step (
            .rem_in (w_rem_c[g]),
            .quo_in (w_quo_c[g]),
            .divisor(r_div),
            .rem_out(w_rem_c[g+1]),
            .quo_out(w_quo_c[g+1])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            DIV_IDLE: if (w_accept && !w_fast) w_state_nxt = DIV_RUN;
            DIV_RUN:  if (r_cnt == CNT_W'(1)) w_state_nxt = DIV_FIX;
            DIV_FIX:  w_state_nxt = DIV_IDLE;
            default:  w_state_nxt = DIV_IDLE;
        endcase
        if (abort) w_state_nxt = DIV_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= DIV_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            unique case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_done <= 1'b0;
                        r_dbz  <= 1'b0;
                        if (w_b_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= data_a;
                            r_done      <= 1'b1;
                            r_dbz       <= 1'b1;
                        end else if (w_ovf) begin
                            r_quotient  <= MIN_VAL;
                            r_remainder <= '0;
                            r_done      <= 1'b1;
                        end else begin
                            r_cnt   <= CNT_W'(ITER);
                            r_rem   <= '0;
                            r_quo   <= w_a_mag;
                            r_div   <= w_b_mag;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                DIV_RUN: begin
                    r_rem <= w_rem_c[BITS_PER_CYCLE];
                    r_quo <= w_quo_c[BITS_PER_CYCLE];
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                DIV_FIX: begin
                    r_quotient  <= r_neg_q ? -r_quo : r_quo;
                    r_remainder <= r_neg_r ? -r_rem : r_rem;
                    r_done      <= 1'b1;
                end
                default: ;
            endcase
            if (abort) begin
                r_done <= 1'b0;
                r_dbz  <= 1'b0;
            end
        end
    end

    assign busy        = (r_state != DIV_IDLE);
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_cpu_divider_n.sv
// Directed self-checking bench for cpu_divider_n (32/1 and 32/2 instances).
module tb_cpu_divider_n;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        start = 1'b0, abort = 1'b0, signed_div = 1'b0;
    logic [31:0] data_a = '0, data_b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    logic        start2 = 1'b0, signed2 = 1'b0;
    logic [31:0] a2 = '0, b2 = '0;
    logic        busy2, done2, dbz2;
    logic [31:0] q2, r2;

    int checks = 0;
    int failures = 0;
    int lat;
    logic held;

    always #5 clock = ~clock;

    cpu_divider_n #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .signed_div(signed_div), .data_a(data_a), .data_b(data_b),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    cpu_divider_n #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .abort(1'b0),
        .signed_div(signed2), .data_a(a2), .data_b(b2),
        .busy(busy2), .done(done2), .quotient(q2), .remainder(r2),
        .div_by_zero(dbz2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one start on the 32/1 instance; lat is the cycle count to done.
    task automatic run1(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int l);
        data_a = a; data_b = b; signed_div = s; start = 1'b1;
        tick();
        start = 1'b0;
        l = 1;
        while (!done && l < 100) begin
            tick();
            l++;
        end
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);

        // 100/7 unsigned with cycle-exact busy/done checks
        data_a = 32'd100; data_b = 32'd7; signed_div = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("u_busy_T1", {31'd0, busy}, 32'd1);
        check("u_done_T1", {31'd0, done}, 32'd0);
        repeat (32) tick();
        check("u_busy_T33", {31'd0, busy}, 32'd1);
        check("u_done_T33", {31'd0, done}, 32'd0);
        tick();
        check("u_done_T34", {31'd0, done}, 32'd1);
        check("u_busy_T34", {31'd0, busy}, 32'd0);
        check("u_q", quotient, 32'd14);
        check("u_r", remainder, 32'd2);
        check("u_dbz", {31'd0, div_by_zero}, 32'd0);

        run1(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
        check("s1_lat", lat, 32'd34);
        check("s1_q", quotient, 32'hFFFF_FFFD);
        check("s1_r", remainder, 32'hFFFF_FFFF);
        run1(32'd7, 32'hFFFF_FFFE, 1'b1, lat);
        check("s2_q", quotient, 32'hFFFF_FFFD);
        check("s2_r", remainder, 32'd1);
        run1(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, lat);
        check("s3_q", quotient, 32'd2);
        check("s3_r", remainder, 32'hFFFF_FFFE);

        run1(32'd5, 32'd0, 1'b0, lat);
        check("dz_lat", lat, 32'd1);
        check("dz_busy", {31'd0, busy}, 32'd0);
        check("dz_q", quotient, 32'hFFFF_FFFF);
        check("dz_r", remainder, 32'd5);
        check("dz_flag", {31'd0, div_by_zero}, 32'd1);

        run1(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
        check("ov_lat", lat, 32'd1);
        check("ov_busy", {31'd0, busy}, 32'd0);
        check("ov_q", quotient, 32'h8000_0000);
        check("ov_r", remainder, 32'd0);
        check("ov_dbz", {31'd0, div_by_zero}, 32'd0);

        // abort mid-run at T+10
        data_a = 32'd1000; data_b = 32'd3; signed_div = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("ab_busy_T10", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", {31'd0, busy}, 32'd0);
        check("ab_done", {31'd0, done}, 32'd0);

        // abort together with start
        data_a = 32'd50; data_b = 32'd5; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abst_busy", {31'd0, busy}, 32'd0);
        check("abst_done", {31'd0, done}, 32'd0);
        tick();
        check("abst_busy2", {31'd0, busy}, 32'd0);

        run1(32'd9, 32'd3, 1'b0, lat);
        check("fr_lat", lat, 32'd34);
        check("fr_q", quotient, 32'd3);
        check("fr_r", remainder, 32'd0);

        // 32/2 instance with an ignored start pulse at T+5
        a2 = 32'hFFFF_FFFF; b2 = 32'd3; signed2 = 1'b0; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("w2_busy_T1", {31'd0, busy2}, 32'd1);
        lat = 1;
        while (!done2 && lat < 100) begin
            if (lat == 5) begin
                a2 = 32'd10; b2 = 32'd2; start2 = 1'b1;
            end
            tick();
            start2 = 1'b0;
            lat++;
        end
        check("w2_lat", lat, 32'd18);
        check("w2_q", q2, 32'h5555_5555);
        check("w2_r", r2, 32'd0);
        check("w2_dbz", {31'd0, dbz2}, 32'd0);
        a2 = 32'd100; b2 = 32'hFFFF_FFF9; signed2 = 1'b1; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 100) begin
            tick();
            lat++;
        end
        check("w2s_lat", lat, 32'd18);
        check("w2s_q", q2, 32'hFFFF_FFF2);
        check("w2s_r", r2, 32'd2);

        // back-to-back: second start in the first done cycle
        run1(32'd100, 32'd7, 1'b0, lat);
        check("bb1_q", quotient, 32'd14);
        data_a = 32'd50; data_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("bb_done_drop", {31'd0, done}, 32'd0);
        check("bb_busy", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        check("bb_lat", lat, 32'd34);
        check("bb_q", quotient, 32'd10);
        check("bb_r", remainder, 32'd0);

        // hold for 50 idle cycles
        held = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!done || quotient !== 32'd10 || remainder !== 32'd0 || busy) held = 1'b0;
        end
        check("hold_all", {31'd0, held}, 32'd1);
        check("hold_done", {31'd0, done}, 32'd1);

        // reset mid-run after setting div_by_zero
        run1(32'd7, 32'd0, 1'b0, lat);
        data_a = 32'd1000; data_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_done", {31'd0, done}, 32'd0);
        check("mr_q", quotient, 32'd0);
        check("mr_r", remainder, 32'd0);
        check("mr_dbz", {31'd0, div_by_zero}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
